// File: rtl/toggle_handshake_sender_pkg.sv
// Shared definitions for the toggle-handshake sender: FSM state encoding,
// synchronizer depth default and a sizing helper for the ack timer.
package toggle_handshake_sender_pkg;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_WAIT_ACK = 1'b1
    } tx_state_t;

    localparam int DEFAULT_SYNC_STAGES = 2;

    // Bits needed to hold 0..limit inclusive, never narrower than one bit.
    function automatic int timer_width(input int limit);
        return (limit < 2) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/toggle_handshake_sender_sync_n.sv
// Plain N-flop synchronizer with asynchronous reset; shared by the send and
// receive sides of the toggle handshake.
module sync_n
    import toggle_handshake_sender_pkg::*;
#(
    parameter int STAGES = DEFAULT_SYNC_STAGES,
    parameter int WIDTH  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage_q [STAGES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q = stage_q[STAGES-1];

endmodule

// File: rtl/toggle_handshake_sender.sv
// Transmit end of a two-phase toggle CDC handshake: holds each accepted word on
// data_out, flips req_toggle, and waits for the synchronized ack to match.
module toggle_handshake_sender
    import toggle_handshake_sender_pkg::*;
#(
    parameter int WIDTH          = 4,
    parameter int SYNC_STAGES    = DEFAULT_SYNC_STAGES,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int COUNT_W        = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [WIDTH-1:0]   in_data,
    output logic               in_ready,
    output logic [WIDTH-1:0]   data_out,
    output logic               req_toggle,
    input  logic               ack_toggle,
    output logic               busy,
    output logic [COUNT_W-1:0] sent_count,
    output logic               err_timeout,
    output logic               err_spurious,
    input  logic               err_clear
);

    localparam int                 TIMER_W    = timer_width(TIMEOUT_CYCLES);
    localparam logic [TIMER_W-1:0] TIMER_MAX  = TIMER_W'(TIMEOUT_CYCLES);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
    localparam bit                 TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

    tx_state_t          state;
    logic               ack_s;
    logic               ack_prev;
    logic [TIMER_W-1:0] timer;
    logic               ack_done;
    logic               timeout_hit;
    logic               spurious_hit;

    sync_n #(
        .STAGES (SYNC_STAGES),
        .WIDTH  (1)
    ) u_ack_sync (
        .clk (clk),
        .rst (rst),
        .d   (ack_toggle),
        .q   (ack_s)
    );

    assign ack_done     = (ack_s == req_toggle);
    assign timeout_hit  = TIMEOUT_EN && (state == ST_WAIT_ACK) && !ack_done
                          && (timer == TIMER_LAST);
    assign spurious_hit = (state == ST_IDLE) && (ack_s != ack_prev);
    assign in_ready     = (state == ST_IDLE) & ~rst;

    // data_out is only loaded on accept, so it cannot move while req and ack differ.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            data_out   <= '0;
            req_toggle <= 1'b0;
            timer      <= '0;
            sent_count <= '0;
            busy       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        data_out   <= in_data;
                        req_toggle <= ~req_toggle;
                        timer      <= '0;
                        state      <= ST_WAIT_ACK;
                        busy       <= 1'b1;
                    end
                end
                ST_WAIT_ACK: begin
                    if (ack_done) begin
                        state      <= ST_IDLE;
                        busy       <= 1'b0;
                        sent_count <= sent_count + COUNT_W'(1);
                    end else if (timer != TIMER_MAX) begin
                        timer <= timer + TIMER_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Sticky supervision flags; a new event in the same cycle as err_clear wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_prev     <= 1'b0;
            err_timeout  <= 1'b0;
            err_spurious <= 1'b0;
        end else begin
            ack_prev     <= ack_s;
            err_timeout  <= (err_timeout & ~err_clear) | timeout_hit;
            err_spurious <= (err_spurious & ~err_clear) | spurious_hit;
        end
    end

endmodule

// File: tb/tb_toggle_handshake_sender.sv
// Loopback bench: a behavioural receiver on its own clock echoes req_toggle back
// as ack_toggle; a scoreboard checks every word it latches plus supervision outputs.
`timescale 1ns/1ps
module tb_toggle_handshake_sender;

    localparam int WIDTH          = 4;
    localparam int SYNC_STAGES    = 2;
    localparam int TIMEOUT_CYCLES = 64;
    localparam int COUNT_W        = 4;

    logic               clk = 1'b0;
    logic               rclk = 1'b0;
    logic               rst = 1'b1;
    logic               in_valid = 1'b0;
    logic [WIDTH-1:0]   in_data = '0;
    logic               in_ready;
    logic [WIDTH-1:0]   data_out;
    logic               req_toggle;
    logic               ack_toggle;
    logic               busy;
    logic [COUNT_W-1:0] sent_count;
    logic               err_timeout;
    logic               err_spurious;
    logic               err_clear = 1'b0;

    int               rxHalf = 10;
    int               echoDelay = 0;
    logic             echoEn = 1'b1;
    logic             ackFlip = 1'b0;
    logic             rq1, rq2, rqSeen, ackEcho, rxStrobe;
    logic [WIDTH-1:0] rxData;
    int               echoCnt;

    int               cyc = 0;
    int               total = 0;
    int               bad = 0;
    int               acceptedTotal = 0;
    logic [WIDTH-1:0] expQ [$];

    toggle_handshake_sender #(
        .WIDTH          (WIDTH),
        .SYNC_STAGES    (SYNC_STAGES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .COUNT_W        (COUNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .data_out     (data_out),
        .req_toggle   (req_toggle),
        .ack_toggle   (ack_toggle),
        .busy         (busy),
        .sent_count   (sent_count),
        .err_timeout  (err_timeout),
        .err_spurious (err_spurious),
        .err_clear    (err_clear)
    );

    always #10 clk = ~clk;

    initial begin
        #3;
        forever #(rxHalf) rclk = ~rclk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    assign ack_toggle = ackEcho ^ ackFlip;

    // Receiver model: synchronize req, latch the word on change, echo after a delay.
    always @(posedge rclk or posedge rst) begin
        if (rst) begin
            rq1      <= 1'b0;
            rq2      <= 1'b0;
            rqSeen   <= 1'b0;
            ackEcho  <= 1'b0;
            echoCnt  <= 0;
            rxStrobe <= 1'b0;
            rxData   <= '0;
        end else begin
            rq1      <= req_toggle;
            rq2      <= rq1;
            rxStrobe <= 1'b0;
            if (rq2 != rqSeen) begin
                rqSeen   <= rq2;
                rxData   <= data_out;
                rxStrobe <= 1'b1;
                echoCnt  <= 0;
            end else if (echoEn && (ackEcho != rqSeen)) begin
                if (echoCnt >= echoDelay) ackEcho <= rqSeen;
                else echoCnt <= echoCnt + 1;
            end
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, want %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [WIDTH-1:0] word, input int gap);
        int waitCnt;
        @(negedge clk);
        if (gap > 0) begin
            in_valid = 1'b0;
            repeat (gap) @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = word;
        waitCnt  = 0;
        while (!in_ready && waitCnt < 500) begin
            @(negedge clk);
            waitCnt++;
        end
        if (!in_ready) begin
            checkOutput("accept_wait", 0, 1);
            in_valid = 1'b0;
        end else begin
            expQ.push_back(word);
            acceptedTotal++;
            @(posedge clk);
        end
    endtask

    task automatic idleInput();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic waitIdle(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!(in_ready && !busy && expQ.size() == 0) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checkOutput({name, "_idle"}, int'(in_ready && !busy && expQ.size() == 0), 1);
        checkOutput({name, "_count"}, int'(sent_count), acceptedTotal % (1 << COUNT_W));
        checkOutput({name, "_req"}, int'(req_toggle), acceptedTotal % 2);
    endtask

    task automatic pulseClear();
        @(negedge clk);
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
    endtask

    task automatic monitorRx();
        forever begin
            @(negedge rclk);
            if (rxStrobe) begin
                if (expQ.size() == 0) checkOutput("rx_unexpected", int'(rxData), -1);
                else checkOutput("rx_data", int'(rxData), int'(expQ.pop_front()));
            end
        end
    endtask

    task automatic monitorHold();
        logic             prevBusy;
        logic [WIDTH-1:0] prevData;
        prevBusy = 1'b0;
        prevData = '0;
        forever begin
            @(negedge clk);
            if (busy && prevBusy) checkOutput("hold_data", int'(data_out), int'(prevData));
            prevBusy = busy;
            prevData = data_out;
        end
    endtask

    initial begin
        int n;
        int flipCyc;
        fork
            monitorRx();
            monitorHold();
        join_none

        repeat (3) @(negedge clk);
        checkOutput("rst_ready", int'(in_ready), 0);
        checkOutput("rst_data", int'(data_out), 0);
        checkOutput("rst_req", int'(req_toggle), 0);
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_count", int'(sent_count), 0);
        checkOutput("rst_errt", int'(err_timeout), 0);
        checkOutput("rst_errs", int'(err_spurious), 0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("ready_after_rst", int'(in_ready), 1);

        $display("[TB] streaming 100 words, matched clocks");
        for (int i = 0; i < 100; i++) applyStimulus(WIDTH'(i % 16), 0);
        idleInput();
        waitIdle("stream");
        checkOutput("stream_errt", int'(err_timeout), 0);
        checkOutput("stream_errs", int'(err_spurious), 0);

        $display("[TB] random gaps, receiver clock 18/22 ns");
        for (int p = 0; p < 2; p++) begin
            rxHalf = (p == 0) ? 9 : 11;
            for (int i = 0; i < 30; i++) begin
                echoDelay = int'($urandom_range(0, 5));
                applyStimulus(WIDTH'($urandom_range(0, 15)), int'($urandom_range(0, 10)));
            end
            idleInput();
            waitIdle("gaps");
        end
        checkOutput("gaps_errt", int'(err_timeout), 0);
        checkOutput("gaps_errs", int'(err_spurious), 0);

        $display("[TB] ack timeout");
        rxHalf = 10;
        echoDelay = 0;
        echoEn = 1'b0;
        applyStimulus(WIDTH'(4'hA), 0);
        idleInput();
        flipCyc = cyc;
        checkOutput("timeout_req", int'(req_toggle), acceptedTotal % 2);
        n = 0;
        while (!err_timeout && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("timeout_delay", cyc - flipCyc, TIMEOUT_CYCLES);
        repeat (10) @(negedge clk);
        checkOutput("timeout_busy", int'(busy), 1);
        checkOutput("timeout_ready", int'(in_ready), 0);
        checkOutput("timeout_data", int'(data_out), 'hA);
        echoEn = 1'b1;
        waitIdle("timeout");
        checkOutput("timeout_sticky", int'(err_timeout), 1);
        pulseClear();
        checkOutput("timeout_cleared", int'(err_timeout), 0);

        $display("[TB] spurious ack");
        checkOutput("spur_pre", int'(err_spurious), 0);
        @(negedge clk);
        ackFlip = 1'b1;
        repeat (SYNC_STAGES) @(negedge clk);
        checkOutput("spur_early", int'(err_spurious), 0);
        @(negedge clk);
        checkOutput("spur_set", int'(err_spurious), 1);
        pulseClear();
        checkOutput("spur_cleared", int'(err_spurious), 0);
        @(negedge clk);
        ackFlip = 1'b0;
        repeat (SYNC_STAGES) @(negedge clk);
        checkOutput("spur_pre2", int'(err_spurious), 0);
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        checkOutput("spur_set_wins", int'(err_spurious), 1);
        pulseClear();
        checkOutput("spur_final", int'(err_spurious), 0);

        $display("[TB] reset during WAIT_ACK");
        echoEn = 1'b0;
        applyStimulus(WIDTH'(4'h5), 0);
        idleInput();
        n = 0;
        while (expQ.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("abort_rx_seen", expQ.size(), 0);
        checkOutput("abort_busy", int'(busy), 1);
        #3;
        rst = 1'b1;
        #1;
        checkOutput("abort_ready", int'(in_ready), 0);
        checkOutput("abort_busy0", int'(busy), 0);
        checkOutput("abort_data", int'(data_out), 0);
        checkOutput("abort_req", int'(req_toggle), 0);
        checkOutput("abort_count", int'(sent_count), 0);
        checkOutput("abort_errt", int'(err_timeout), 0);
        acceptedTotal = 0;
        echoEn = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(WIDTH'(4'h3), 0);
        idleInput();
        waitIdle("post_reset");

        $display("[TB] counter wrap");
        for (int i = 0; i < 16; i++)
            applyStimulus(WIDTH'($urandom_range(0, 15)), int'($urandom_range(0, 2)));
        idleInput();
        waitIdle("wrap");
        checkOutput("wrap_count17", int'(sent_count), 1);
        checkOutput("final_errs", int'(err_spurious), 0);
        checkOutput("rx_missing", expQ.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5ms;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
